// File: rtl/p_emap_writeback.sv
// Write-side packer for the P_Emap vector memory: gathers a valid/ready element
// stream into no_of_units-wide lines and issues one registered line write per flush.
module p_emap_writeback #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic                                 in_valid,
  input  logic [element_width-1:0]             in_data,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic                                 write_enable,
  output logic [address_width-1:0]             write_address,
  output logic [no_of_units*element_width-1:0] write_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(no_of_units - 1);
  localparam logic [address_width-1:0] TOP_LINE  = address_width'(memory_height);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t                                       state;
  logic [LANE_W-1:0]                            lane_cnt;
  logic [address_width-1:0]                     line_addr;
  logic [no_of_units-1:0][element_width-1:0]    line_buf;
  logic [no_of_units*element_width-1:0]         merged_line;
  logic                                         accept;
  logic                                         flush;
  logic                                         addr_ok;

  // in_ready is a registered copy of "state == FILL", so it doubles as the accept gate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    merged_line = '0;
    accept      = in_valid && in_ready;
    flush       = accept && ((lane_cnt == LAST_LANE) || in_last);
    addr_ok     = (line_addr <= TOP_LINE);
    // Lane 0 occupies the most significant element slot, matching the gather side.
    for (int r = 0; r < no_of_units; r++) begin
      merged_line[(no_of_units-r)*element_width-1 -: element_width] =
        (LANE_W'(r) == lane_cnt) ? in_data : line_buf[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the line buffer is reset too, because unfilled lanes of a partial line must read zero.
      state         <= IDLE;
      lane_cnt      <= '0;
      line_addr     <= '0;
      line_buf      <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
      write_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            line_addr <= base_address;
            lane_cnt  <= '0;
            line_buf  <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (flush) begin
              line_buf <= '0;
              lane_cnt <= '0;
              if (addr_ok) begin
                write_enable  <= 1'b1;
                write_address <= line_addr;
                write_data    <= merged_line;
                // Stops one past the top line, so an out-of-range stream never wraps back in range.
                line_addr     <= line_addr + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              line_buf[lane_cnt] <= in_data;
              lane_cnt           <= lane_cnt + 1'b1;
            end
            if (in_last) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p_emap_writeback.sv
// Randomised bench for p_emap_writeback: an element-indexed reference model predicts
// every output each cycle, plus literal expectations for the directed vectors.
module tb_p_emap_writeback;

  localparam int N      = 8;
  localparam int W      = 32;
  localparam int MH     = 1000;
  localparam int ADDR_W = $clog2(MH) + 1;
  localparam int DW     = N * W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_address;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_last;
  logic              in_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DW-1:0]     write_data;
  logic              busy;
  logic              done;
  logic              overflow;

  p_emap_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_address (base_address),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 collecting a vector, 2 done cycle.
  int                m_phase = 0;
  logic [ADDR_W-1:0] m_base  = '0;
  logic [W-1:0]      vec[$];
  logic              exp_in_ready, exp_busy, exp_done, exp_we, exp_overflow, exp_chk_addr;
  logic [ADDR_W-1:0] exp_addr;
  logic [DW-1:0]     exp_data;

  // Writes observed on the DUT port, for the literal pins.
  logic [ADDR_W-1:0] wlog_addr[$];
  logic [DW-1:0]     wlog_data[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic st, input logic [ADDR_W-1:0] ba, input logic v,
                            input logic [W-1:0] d, input logic l, input logic rst);
    int k, line, addr;
    logic [DW-1:0] data;
    exp_chk_addr = 1'b0;
    exp_we       = 1'b0;
    exp_done     = 1'b0;
    if (rst) begin
      m_phase      = 0;
      vec.delete();
      exp_overflow = 1'b0;
      exp_addr     = '0;
      exp_data     = '0;
      exp_chk_addr = 1'b1;
    end else begin
      case (m_phase)
        0: if (st) begin
          m_phase      = 1;
          m_base       = ba;
          vec.delete();
          exp_overflow = 1'b0;
        end
        1: if (v) begin
          vec.push_back(d);
          k = vec.size() - 1;
          if ((k % N) == N - 1 || l) begin
            line = k / N;
            addr = int'(m_base) + line;
            data = '0;
            for (int j = line * N; j <= k; j++) data[(N-(j%N))*W-1 -: W] = vec[j];
            if (addr <= MH) begin
              exp_we   = 1'b1;
              exp_addr = ADDR_W'(addr);
              exp_data = data;
            end else begin
              exp_overflow = 1'b1;
            end
          end
          if (l) begin
            m_phase  = 2;
            exp_done = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
    exp_in_ready = (m_phase == 1);
    exp_busy     = (m_phase == 1);
  endtask

  task automatic compare();
    check("in_ready", {255'b0, in_ready}, {255'b0, exp_in_ready});
    check("busy", {255'b0, busy}, {255'b0, exp_busy});
    check("done", {255'b0, done}, {255'b0, exp_done});
    check("write_enable", {255'b0, write_enable}, {255'b0, exp_we});
    check("overflow", {255'b0, overflow}, {255'b0, exp_overflow});
    if (exp_we || exp_chk_addr) begin
      check("write_address", {{(DW-ADDR_W){1'b0}}, write_address}, {{(DW-ADDR_W){1'b0}}, exp_addr});
      check("write_data", write_data, exp_data);
    end
    if (write_enable === 1'b1) begin
      wlog_addr.push_back(write_address);
      wlog_data.push_back(write_data);
    end
  endtask

  // Drive inputs after the falling edge, let the DUT sample them, then compare 1 ns later.
  task automatic step(input logic st, input logic [ADDR_W-1:0] ba, input logic v,
                      input logic [W-1:0] d, input logic l, input logic rst);
    @(negedge clk);
    start        = st;
    base_address = ba;
    in_valid     = v;
    in_data      = d;
    in_last      = l;
    reset        = rst;
    @(posedge clk);
    model_edge(st, ba, v, d, l, rst);
    #1;
    compare();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Start, then n elements; gap < 0 means random 0..2 idle cycles before each element.
  // Ends on the cycle that accepts in_last (the caller decides what follows).
  task automatic run_vector(input int base, input int n, input int d0, input bit rnd, input int gap);
    int g;
    step(1'b1, ADDR_W'(base), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        if (rnd) step(($urandom % 4) == 0, ADDR_W'($urandom), 1'b0, $urandom, 1'($urandom), 1'b0);
        else idle();
      end
      step(1'b0, '0, 1'b1, rnd ? $urandom : W'(d0 + i), (i == n - 1), 1'b0);
    end
  endtask

  initial begin
    int w0;
    start = 1'b0; base_address = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reset = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("reset_write_data_zero", write_data, '0);

    // Two full lines at base 5, done coincident with the second write.
    w0 = wlog_addr.size();
    run_vector(5, 16, 1, 1'b0, 0);
    check("t1_done_with_write", {254'b0, done, write_enable}, 256'd3);
    idle();
    check("t1_write_count", DW'(wlog_addr.size() - w0), 256'd2);
    check("t1_line5_addr", DW'(wlog_addr[w0]), 256'd5);
    check("t1_line5_data", wlog_data[w0],
          256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    check("t1_line6_addr", DW'(wlog_addr[w0+1]), 256'd6);
    check("t1_line6_data", wlog_data[w0+1],
          256'h00000009_0000000A_0000000B_0000000C_0000000D_0000000E_0000000F_00000010);

    // Partial line with zero-filled tail lanes.
    w0 = wlog_addr.size();
    run_vector(0, 3, 'hA, 1'b0, 0);
    check("t2_done_with_write", {254'b0, done, write_enable}, 256'd3);
    idle();
    check("t2_line0_addr", DW'(wlog_addr[w0]), 256'd0);
    check("t2_line0_data", wlog_data[w0],
          256'h0000000A_0000000B_0000000C_00000000_00000000_00000000_00000000_00000000);

    // Gapless vs one-in-three valid: same line content.
    w0 = wlog_addr.size();
    run_vector(20, 8, 'h100, 1'b0, 0);
    idle();
    run_vector(20, 8, 'h100, 1'b0, 2);
    idle();
    check("t3_write_count", DW'(wlog_addr.size() - w0), 256'd2);
    check("t3_gapless_data", wlog_data[w0],
          256'h00000100_00000101_00000102_00000103_00000104_00000105_00000106_00000107);
    check("t3_gapped_data", wlog_data[w0+1],
          256'h00000100_00000101_00000102_00000103_00000104_00000105_00000106_00000107);

    // Top line written, next line suppressed, overflow sticky until next start.
    w0 = wlog_addr.size();
    run_vector(MH, 12, 'h50, 1'b0, 0);
    idle();
    idle();
    check("t4_overflow_sticky", {255'b0, overflow}, 256'd1);
    check("t4_write_count", DW'(wlog_addr.size() - w0), 256'd1);
    check("t4_top_addr", DW'(wlog_addr[w0]), DW'(MH));

    // Reset after five accepted elements: nothing written, fresh start afterwards.
    w0 = wlog_addr.size();
    step(1'b1, ADDR_W'(40), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, W'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("t5_no_write", DW'(wlog_addr.size() - w0), 256'd0);
    run_vector(50, 3, 'h7, 1'b0, 0);
    idle();
    check("t5_fresh_base", DW'(wlog_addr[w0]), 256'd50);

    // Reset on the very edge that would accept the line-completing element.
    w0 = wlog_addr.size();
    step(1'b1, ADDR_W'(60), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, W'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 'hFF, 1'b0, 1'b1);
    idle();
    check("t5b_flush_cancelled", DW'(wlog_addr.size() - w0), 256'd0);

    // Back-to-back vectors; start during DONE must be ignored.
    w0 = wlog_addr.size();
    run_vector(100, 4, 'h20, 1'b0, 0);
    step(1'b1, ADDR_W'(300), 1'b0, '0, 1'b0, 1'b0);
    run_vector(200, 9, 'h30, 1'b0, 0);
    idle();
    check("t6_first_base", DW'(wlog_addr[w0]), 256'd100);
    check("t6_second_base", DW'(wlog_addr[w0+1]), 256'd200);
    check("t6_second_lane0", DW'(wlog_data[w0+1][DW-1 -: W]), 256'h30);

    // Random vectors with gaps, noise on ignored inputs, and bases near the top line.
    for (int t = 0; t < 40; t++) begin
      int base;
      base = ($urandom % 2) ? int'($urandom_range(0, MH - 10)) : int'($urandom_range(MH - 5, MH));
      run_vector(base, int'($urandom_range(1, 20)), 0, 1'b1, -1);
      step(1'b1, ADDR_W'($urandom), 1'b1, $urandom, 1'b1, 1'b0);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        step(1'b0, '0, 1'($urandom), $urandom, 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
